macrocell_fuse_loader: RTL and testbench

Serial fuse loader that writes one macrocell's configuration: it accepts a bit stream under a valid/ready handshake and assembles the 501 fuse bits that the macrocell consumes as its mux controls. Bits accumulate in a shadow register and are committed atomically to the output configuration only when a complete (and, optionally, CRC-checked) frame has arrived. It sits between the device-level JEDEC/JTAG programming path and each macrocell instance, one loader per macrocell.

---
 rtl/macrocell_fuse_loader_pkg.sv | 10 +
 rtl/macrocell_fuse_loader_if.sv | 12 +
 rtl/macrocell_fuse_loader_crc8.sv | 15 +
 rtl/macrocell_fuse_loader.sv | 119 +++++++++++
 tb/tb_macrocell_fuse_loader.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/macrocell_fuse_loader_pkg.sv
// mc_fuse_pkg: shared fuse-frame layout, CRC polynomial and loader state encoding
package mc_fuse_pkg;
  localparam int FUSE_BITS = 501;
  localparam int PT_BASE = 0;
  localparam int CTL_BASE = 480;
  localparam int GCLK_BASE = 496;
  localparam int OE_BASE = 498;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_COMMIT} state_t;
endpackage

// File: rtl/macrocell_fuse_loader_if.sv
// macrocell_fuse_loader_if: serial fuse stream handshake and frame status
interface macrocell_fuse_loader_if;
  logic start;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic busy;
  logic done;
  logic crc_err;
  modport master(output start, bit_in, bit_valid, input bit_ready, busy, done, crc_err);
  modport slave(input start, bit_in, bit_valid, output bit_ready, busy, done, crc_err);
endinterface

// File: rtl/macrocell_fuse_loader_crc8.sv
// crc8_serial: one-bit-per-cycle CRC-8 (poly 0x07, init 0), clear has priority over enable
module crc8_serial
  import mc_fuse_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       d,
  output logic [7:0] crc
);
  // shift the incoming bit through the CRC register
  always_ff @(posedge clk)
    crc <= (rst || clr) ? 8'h00 : en ? ({crc[6:0], 1'b0} ^ ((crc[7] ^ d) ? CRC8_POLY : 8'h00)) : crc;
endmodule

// File: rtl/macrocell_fuse_loader.sv
// macrocell_fuse_loader: serial 501-bit fuse frame loader with atomic commit; MC_FUSE_CRC_EN adds CRC-8 trailer check
module macrocell_fuse_loader
  import mc_fuse_pkg::*;
(
  input  logic clk,
  input  logic rst,
  macrocell_fuse_loader_if.slave bus,
  output logic [0:479] ptgroupbitmap_mux,
  output logic [0:15] fuse_ctl,
  output logic [0:1] gclk_mux,
  output logic [0:2] oe_mux
);
  state_t state;
  logic [8:0] cnt;
  logic [0:FUSE_BITS-1] shadow;
  logic [0:FUSE_BITS-1] cfg;
  logic rdy;
  logic bsy;
  logic dn;
  logic acc;
  assign acc = bus.bit_valid && rdy;
  assign bus.bit_ready = rdy;
  assign bus.busy = bsy;
  assign bus.done = dn;
  assign ptgroupbitmap_mux = cfg[PT_BASE +: 480];
  assign fuse_ctl = cfg[CTL_BASE +: 16];
  assign gclk_mux = cfg[GCLK_BASE +: 2];
  assign oe_mux = cfg[OE_BASE +: 3];
`ifdef MC_FUSE_CRC_EN
  logic [7:0] crc;
  logic [7:0] trl;
  logic [2:0] tcnt;
  logic err;
  assign bus.crc_err = err;
  crc8_serial u_crc (
    .clk(clk),
    .rst(rst),
    .clr(state == S_IDLE && bus.start),
    .en(state == S_LOAD && acc),
    .d(bus.bit_in),
    .crc(crc)
  );
`else
  assign bus.crc_err = 1'b0;
`endif
  // frame FSM: shadow fill, optional trailer capture, then a one-cycle commit
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      shadow <= '0;
      cfg <= '0;
      rdy <= 1'b0;
      bsy <= 1'b0;
      dn <= 1'b0;
`ifdef MC_FUSE_CRC_EN
      trl <= '0;
      tcnt <= '0;
      err <= 1'b0;
`endif
    end else begin
      dn <= 1'b0;
`ifdef MC_FUSE_CRC_EN
      err <= 1'b0;
`endif
      case (state)
        S_IDLE: if (bus.start) begin
          cnt <= '0;
          state <= S_LOAD;
          rdy <= 1'b1;
          bsy <= 1'b1;
`ifdef MC_FUSE_CRC_EN
          tcnt <= '0;
`endif
        end
        S_LOAD: if (acc) begin
          shadow[cnt] <= bus.bit_in;
          cnt <= cnt + 9'd1;
          if (cnt == 9'(FUSE_BITS - 1)) begin
`ifdef MC_FUSE_CRC_EN
            state <= S_CHECK;
`else
            state <= S_COMMIT;
            rdy <= 1'b0;
            bsy <= 1'b0;
`endif
          end
        end
        S_CHECK: begin
`ifdef MC_FUSE_CRC_EN
          if (acc) begin
            trl <= {trl[6:0], bus.bit_in};
            tcnt <= tcnt + 3'd1;
            if (tcnt == 3'd7) begin
              state <= S_COMMIT;
              rdy <= 1'b0;
              bsy <= 1'b0;
            end
          end
`else
          state <= S_IDLE;
`endif
        end
        default: begin
          state <= S_IDLE;
`ifdef MC_FUSE_CRC_EN
          if (trl == crc) begin
            cfg <= shadow;
            dn <= 1'b1;
          end else err <= 1'b1;
`else
          cfg <= shadow;
          dn <= 1'b1;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_macrocell_fuse_loader.sv
// tb_macrocell_fuse_loader: scoreboard bench with randomized frames against a frame-level reference model
module tb_macrocell_fuse_loader;
  import mc_fuse_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  macrocell_fuse_loader_if bus();
  logic [0:479] pt;
  logic [0:15] ctl;
  logic [0:1] gclk;
  logic [0:2] oe;
  macrocell_fuse_loader dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ptgroupbitmap_mux(pt),
    .fuse_ctl(ctl),
    .gclk_mux(gclk),
    .oe_mux(oe)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic ok;
    logic [0:500] cfg;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  logic [0:500] committed = '0;
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  function automatic logic [0:500] outs();
    return {pt, ctl, gclk, oe};
  endfunction
  function automatic logic [7:0] crc_of(input logic [0:500] f);
    logic [7:0] c = 8'h00;
    for (int k = 0; k < 501; k++) begin
      logic fb = c[7] ^ f[k];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
  // monitor: every done/crc_err pulse must match the oldest expected commit outcome
  always @(posedge clk) begin
    #1;
    if (!rst && (bus.done || bus.crc_err)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse done=%0b crc_err=%0b required=none", bus.done, bus.crc_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_done", 512'(bus.done), 512'(e.ok));
        check("pulse_crc_err", 512'(bus.crc_err), 512'(!e.ok));
        check("commit_cfg", 512'(outs()), 512'(e.cfg));
      end
    end
  end
  task automatic drive_bit(input logic b, input int gap);
    int budget = 0;
    while ($urandom_range(99) < gap) begin
      bus.bit_valid = 1'b0;
      bus.bit_in = 1'($urandom);
      bus.start = ($urandom_range(15) == 0);
      @(negedge clk);
    end
    bus.bit_in = b;
    bus.bit_valid = 1'b1;
    bus.start = ($urandom_range(15) == 0);
    while (!bus.bit_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.bit_ready) begin
      checks++;
      failures++;
      $display("FAIL bit_ready_timeout actual=0 required=1");
    end
    @(negedge clk);
  endtask
  task automatic run_frame(input logic [0:500] f, input logic [7:0] tr, input int gap);
    exp_t e;
`ifdef MC_FUSE_CRC_EN
    e.ok = (tr == crc_of(f));
`else
    e.ok = 1'b1;
`endif
    e.cfg = e.ok ? f : committed;
    committed = e.cfg;
    q.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_in_load", 512'(bus.busy), 512'(1));
    check("ready_in_load", 512'(bus.bit_ready), 512'(1));
    for (int k = 0; k < FUSE_BITS; k++) drive_bit(f[k], gap);
`ifdef MC_FUSE_CRC_EN
    for (int i = 7; i >= 0; i--) drive_bit(tr[i], gap);
`endif
    bus.bit_valid = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_ready", 512'(bus.bit_ready), 512'(0));
    check("idle_busy", 512'(bus.busy), 512'(0));
    check("pulse_seen", 512'(q.size()), 512'(0));
    check("held_cfg", 512'(outs()), 512'(committed));
  endtask
  initial begin
    logic [0:500] f;
    bus.start = 1'b0;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cfg", 512'(outs()), 512'(0));
    check("reset_ready", 512'(bus.bit_ready), 512'(0));
    check("reset_busy", 512'(bus.busy), 512'(0));
    check("reset_done", 512'(bus.done), 512'(0));
    check("reset_crc_err", 512'(bus.crc_err), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    run_frame('0, 8'h00, 0);
    f = '0;
    f[500] = 1'b1;
    run_frame(f, 8'h07, 0);
    check("oe_only_bit500", 512'(oe), 512'(3'b001));
    check("pt_zero", 512'(pt), 512'(0));
    check("ctl_gclk_zero", 512'({ctl, gclk}), 512'(0));
    run_frame(f, 8'h06, 10);
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 501; k++) f[k] = 1'($urandom);
      run_frame(f, crc_of(f), 50);
    end
    for (int k = 0; k < 501; k++) f[k] = 1'($urandom);
    run_frame(f, crc_of(f) ^ 8'(1 << $urandom_range(7)), 30);
    for (int i = 0; i < 8; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in = 1'($urandom);
      @(negedge clk);
      check("idle_ignores_bits", 512'(bus.bit_ready), 512'(0));
    end
    bus.bit_valid = 1'b0;
    check("idle_cfg_held", 512'(outs()), 512'(committed));
    for (int k = 0; k < 501; k++) f[k] = 1'($urandom);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 251; k++) drive_bit(f[k], 20);
    bus.bit_valid = 1'b0;
    bus.start = 1'b0;
    rst = 1'b1;
    committed = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_cfg", 512'(outs()), 512'(0));
    check("abort_busy", 512'(bus.busy), 512'(0));
    check("abort_ready", 512'(bus.bit_ready), 512'(0));
    run_frame(f, crc_of(f), 40);
    repeat (3) @(negedge clk);
    check("queue_empty", 512'(q.size()), 512'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
